// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the memory-access (LSU) pipeline stage:
//               load funct3 codes, one-hot store length codes, FSM state
//               encoding, default widths and size/alignment/mask helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int XLEN_DEF        = 64;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Load funct3 encodings
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    // Store length, one-hot
    localparam logic [3:0] ST_B = 4'b0001;
    localparam logic [3:0] ST_H = 4'b0010;
    localparam logic [3:0] ST_W = 4'b0100;
    localparam logic [3:0] ST_D = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // log2 of the access size in bytes (0=B, 1=H, 2=W, 3=D).
    // For loads funct3[1:0] already encodes this directly.
    function automatic logic [1:0] access_size(input logic       is_load,
                                               input logic [2:0] ld_op,
                                               input logic [3:0] st_len);
        logic [1:0] size;
        if (is_load) begin
            size = ld_op[1:0];
        end else begin
            case (st_len)
                ST_B:    size = 2'd0;
                ST_H:    size = 2'd1;
                ST_W:    size = 2'd2;
                ST_D:    size = 2'd3;
                default: size = 2'd3;
            endcase
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] off);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

    function automatic logic [7:0] store_mask(input logic [1:0] size,
                                              input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01 << off;
            2'd1:    mask = 8'h03 << off;
            2'd2:    mask = 8'h0F << off;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load formatter. Shifts the 8-byte bus word down
//               by the byte offset and sign/zero-extends per load funct3.
// Ports       : rdata       in  XLEN  raw doubleword from memory
//               offset      in  3     byte offset within the doubleword
//               load_opcode in  3     load funct3
//               load_data   out XLEN  formatted load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      load_opcode,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        load_data = '0;
        case (load_opcode)
            LD_LB:  load_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            LD_LH:  load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            LD_LW:  load_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            LD_LD:  load_data = w_shifted;
            LD_LBU: load_data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            LD_LHU: load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            LD_LWU: load_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage
// Description : Memory-access stage of the 5-stage RV64 pipeline. Converts
//               the EX->MEM register contents into a valid/ready request and
//               response transaction, stalls upstream while it is in flight,
//               and produces the MEM->WB register (lsu_*).
// Ports       : clk, rstn                    clock, async active-low reset
//               exu_*                        EX->MEM register fields
//               mem_req_valid/ready/we/addr/wdata/wmask  request channel
//               mem_rsp_valid/rdata          response channel
//               lsu_stall                    hold IF/ID/EX registers
//               lsu_*                        MEM->WB register fields
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            exu_execute_en,
    input  logic            exu_load_en,
    input  logic            exu_store_en,
    input  logic [2:0]      exu_load_opcode,
    input  logic [3:0]      exu_store_len,
    input  logic [XLEN-1:0] exu_alu_result,
    input  logic [XLEN-1:0] exu_gpr_data2,
    input  logic [4:0]      exu_index_rd,
    input  logic            exu_wb_en,
    input  logic [3:0]      exu_wb_choose,
    input  logic            exu_ebreak,
    input  logic [XLEN-1:0] exu_pc,
    input  logic [XLEN-1:0] exu_snxt_pc,
    input  logic [31:0]     exu_instr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    output logic            lsu_stall,
    output logic            lsu_execute_en,
    output logic            lsu_wb_en,
    output logic            lsu_ebreak,
    output logic [4:0]      lsu_index_rd,
    output logic [3:0]      lsu_wb_choose,
    output logic [XLEN-1:0] lsu_alu_result,
    output logic [XLEN-1:0] lsu_load_data,
    output logic [XLEN-1:0] lsu_pc,
    output logic [XLEN-1:0] lsu_snxt_pc,
    output logic [31:0]     lsu_instr,
    output logic            lsu_misalign,
    output logic            lsu_bus_err
);

    localparam int              CNT_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  r_wdata;
    logic [7:0]       r_wmask;
    logic [2:0]       r_ld_op;
    logic [2:0]       r_off;
    logic [XLEN-1:0]  r_rdata;
    logic             r_bus_err;

    logic             w_mem_op;
    logic [2:0]       w_off;
    logic [1:0]       w_size;
    logic             w_misalign;
    logic             w_start;
    logic             w_expire;
    logic [XLEN-1:0]  w_ld_fmt;

    logic             w_capture;
    logic             w_wb_nxt;
    logic             w_mis_nxt;
    logic             w_berr_nxt;
    logic [XLEN-1:0]  w_ldata_nxt;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_mem_op   = exu_execute_en & (exu_load_en | exu_store_en);
    assign w_off      = exu_alu_result[2:0];
    assign w_size     = access_size(exu_load_en, exu_load_opcode, exu_store_len);
    assign w_misalign = is_misaligned(w_size, w_off);
    assign w_start    = (r_state == S_IDLE) & w_mem_op & ~w_misalign;

    // Timeout only fires when the event we are waiting for did not arrive
    // in the same cycle; a last-cycle handshake/response still completes.
    assign w_expire = (r_cnt == C_CNT_LAST) &
                      (((r_state == S_REQ) & ~mem_req_ready) |
                       ((r_state == S_RSP) & ~mem_rsp_valid));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        lsu_stall     = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                lsu_stall = w_start;
                if (w_start) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                lsu_stall     = 1'b1;
                mem_req_valid = 1'b1;
                // A response coinciding with the handshake is not legal
                // and is ignored here.
                if (mem_req_ready) begin
                    w_state_nxt = r_we ? S_DONE : S_RSP;
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RSP: begin
                lsu_stall = 1'b1;
                if (mem_rsp_valid || w_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request registers, timeout counter, response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_ld_op   <= '0;
            r_off     <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt     <= '0;
                r_we      <= ~exu_load_en;
                r_addr    <= {exu_alu_result[XLEN-1:3], 3'b000};
                r_wmask   <= exu_load_en ? 8'h00 : store_mask(w_size, w_off);
                r_wdata   <= exu_load_en ? '0 : (exu_gpr_data2 << {w_off, 3'b000});
                r_ld_op   <= exu_load_opcode;
                r_off     <= w_off;
                r_bus_err <= 1'b0;
            end else if ((r_state == S_REQ) || (r_state == S_RSP)) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_expire) begin
                    r_bus_err <= 1'b1;
                end
            end
            if ((r_state == S_RSP) && mem_rsp_valid) begin
                r_rdata <= mem_rsp_rdata;
            end
        end
    end

    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata       (r_rdata),
        .offset      (r_off),
        .load_opcode (r_ld_op),
        .load_data   (w_ld_fmt)
    );

    // ------------------------------------------------------------------
    // MEM->WB register. The EX register is held by lsu_stall, so the
    // exu_* fields still describe the memory instruction in DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_capture   = 1'b0;
        w_wb_nxt    = 1'b0;
        w_mis_nxt   = 1'b0;
        w_berr_nxt  = 1'b0;
        w_ldata_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_start) begin
                    w_capture = 1'b1;
                    w_mis_nxt = w_mem_op & w_misalign;
                    w_wb_nxt  = exu_wb_en & ~w_mis_nxt;
                end
            end
            S_DONE: begin
                w_capture   = 1'b1;
                w_berr_nxt  = r_bus_err;
                w_wb_nxt    = exu_wb_en & ~r_bus_err;
                w_ldata_nxt = (r_we || r_bus_err) ? '0 : w_ld_fmt;
            end
            default: begin
                w_capture = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lsu_execute_en <= 1'b0;
            lsu_wb_en      <= 1'b0;
            lsu_ebreak     <= 1'b0;
            lsu_index_rd   <= '0;
            lsu_wb_choose  <= '0;
            lsu_alu_result <= '0;
            lsu_load_data  <= '0;
            lsu_pc         <= '0;
            lsu_snxt_pc    <= '0;
            lsu_instr      <= '0;
            lsu_misalign   <= 1'b0;
            lsu_bus_err    <= 1'b0;
        end else if (w_capture) begin
            lsu_execute_en <= exu_execute_en;
            lsu_wb_en      <= w_wb_nxt;
            lsu_ebreak     <= exu_ebreak;
            lsu_index_rd   <= exu_index_rd;
            lsu_wb_choose  <= exu_wb_choose;
            lsu_alu_result <= exu_alu_result;
            lsu_load_data  <= w_ldata_nxt;
            lsu_pc         <= exu_pc;
            lsu_snxt_pc    <= exu_snxt_pc;
            lsu_instr      <= exu_instr;
            lsu_misalign   <= w_mis_nxt;
            lsu_bus_err    <= w_berr_nxt;
        end else begin
            // Bubble while the memory transaction is outstanding
            lsu_execute_en <= 1'b0;
            lsu_wb_en      <= 1'b0;
            lsu_ebreak     <= 1'b0;
            lsu_index_rd   <= '0;
            lsu_wb_choose  <= '0;
            lsu_alu_result <= '0;
            lsu_load_data  <= '0;
            lsu_pc         <= '0;
            lsu_snxt_pc    <= '0;
            lsu_instr      <= '0;
            lsu_misalign   <= 1'b0;
            lsu_bus_err    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_stage
// Description : Self-checking bench for lsu_stage. Directed vector table with
//               a responsive memory model, plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        exu_execute_en, exu_load_en, exu_store_en, exu_wb_en, exu_ebreak;
    logic [2:0]  exu_load_opcode;
    logic [3:0]  exu_store_len, exu_wb_choose;
    logic [63:0] exu_alu_result, exu_gpr_data2, exu_pc, exu_snxt_pc;
    logic [4:0]  exu_index_rd;
    logic [31:0] exu_instr;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic        lsu_stall, lsu_execute_en, lsu_wb_en, lsu_ebreak, lsu_misalign, lsu_bus_err;
    logic [4:0]  lsu_index_rd;
    logic [3:0]  lsu_wb_choose;
    logic [63:0] lsu_alu_result, lsu_load_data, lsu_pc, lsu_snxt_pc;
    logic [31:0] lsu_instr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk(clk), .rstn(rstn),
        .exu_execute_en(exu_execute_en), .exu_load_en(exu_load_en), .exu_store_en(exu_store_en),
        .exu_load_opcode(exu_load_opcode), .exu_store_len(exu_store_len),
        .exu_alu_result(exu_alu_result), .exu_gpr_data2(exu_gpr_data2),
        .exu_index_rd(exu_index_rd), .exu_wb_en(exu_wb_en), .exu_wb_choose(exu_wb_choose),
        .exu_ebreak(exu_ebreak), .exu_pc(exu_pc), .exu_snxt_pc(exu_snxt_pc), .exu_instr(exu_instr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .lsu_stall(lsu_stall), .lsu_execute_en(lsu_execute_en), .lsu_wb_en(lsu_wb_en),
        .lsu_ebreak(lsu_ebreak), .lsu_index_rd(lsu_index_rd), .lsu_wb_choose(lsu_wb_choose),
        .lsu_alu_result(lsu_alu_result), .lsu_load_data(lsu_load_data), .lsu_pc(lsu_pc),
        .lsu_snxt_pc(lsu_snxt_pc), .lsu_instr(lsu_instr),
        .lsu_misalign(lsu_misalign), .lsu_bus_err(lsu_bus_err)
    );

    typedef struct {
        logic        exec, ld, st;
        logic [2:0]  op;
        logic [3:0]  len;
        logic [63:0] addr, data2, rdata;
        int          dly;
        logic        rdy, early, wb_in;
        int          exp_lat, exp_nvalid;
        logic [63:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata, exp_ldata;
        logic        exp_wb, exp_mis, exp_berr;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk_ld(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] rdata,
                                   input int dly, input int lat, input logic [63:0] eaddr,
                                   input logic [63:0] ldata, input logic mis);
        vec_t v;
        v.exec = 1'b1; v.ld = 1'b1; v.st = 1'b0; v.op = op; v.len = 4'b0000;
        v.addr = addr; v.data2 = 64'h0; v.rdata = rdata; v.dly = dly;
        v.rdy = 1'b1; v.early = 1'b0; v.wb_in = 1'b1;
        v.exp_lat = lat; v.exp_nvalid = mis ? 0 : 1; v.exp_addr = eaddr; v.exp_we = 1'b0;
        v.exp_wmask = 8'h00; v.exp_wdata = 64'h0; v.exp_ldata = ldata;
        v.exp_wb = ~mis; v.exp_mis = mis; v.exp_berr = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_st(input logic [3:0] len, input logic [63:0] addr, input logic [63:0] data2,
                                   input int lat, input logic [63:0] eaddr, input logic [7:0] wmask,
                                   input logic [63:0] wdata, input logic mis);
        vec_t v;
        v = mk_ld(3'b000, addr, 64'h0, 1, lat, eaddr, 64'h0, mis);
        v.ld = 1'b0; v.st = 1'b1; v.len = len; v.data2 = data2; v.wb_in = 1'b0;
        v.exp_we = 1'b1; v.exp_wmask = wmask; v.exp_wdata = wdata; v.exp_wb = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_alu(input logic [63:0] res);
        vec_t v;
        v = mk_ld(3'b000, res, 64'h0, 1, 1, 64'h0, 64'h0, 1'b0);
        v.ld = 1'b0; v.exp_nvalid = 0;
        return v;
    endfunction

    task automatic drive_idle();
        exu_execute_en = 0; exu_load_en = 0; exu_store_en = 0; exu_wb_en = 0; exu_ebreak = 0;
        exu_load_opcode = 0; exu_store_len = 0; exu_wb_choose = 0; exu_index_rd = 0;
        exu_alu_result = 0; exu_gpr_data2 = 0; exu_pc = 0; exu_snxt_pc = 0; exu_instr = 0;
    endtask

    // Presents one instruction and acts as memory until the stage consumes it.
    task automatic run_vec(input string tag, input vec_t v, input int idx);
        int cyc, stalls, nvalid, rsp_cnt;
        bit done, hs_pend, seen_we;
        logic [63:0] s_addr, s_wdata;
        logic [7:0]  s_wmask;
        exu_execute_en = v.exec; exu_load_en = v.ld; exu_store_en = v.st;
        exu_load_opcode = v.op; exu_store_len = v.len; exu_alu_result = v.addr;
        exu_gpr_data2 = v.data2; exu_wb_en = v.wb_in; exu_ebreak = 1'b0;
        exu_index_rd = 5'(idx + 1); exu_wb_choose = 4'b0010;
        exu_pc = 64'h8000_0000 + 64'(idx * 4); exu_snxt_pc = exu_pc + 64'd4;
        exu_instr = 32'h0000_1000 + 32'(idx);
        cyc = 0; stalls = 0; nvalid = 0; rsp_cnt = 0; done = 0;
        seen_we = 0; s_addr = 0; s_wdata = 0; s_wmask = 0;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (lsu_stall) stalls++;
            mem_req_ready = 0; mem_rsp_valid = 0; hs_pend = 0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rsp_valid = 1; mem_rsp_rdata = v.rdata;
                end
            end
            if (mem_req_valid) begin
                nvalid++;
                s_addr = mem_req_addr; seen_we = mem_req_we;
                s_wdata = mem_req_wdata; s_wmask = mem_req_wmask;
                if (v.rdy) begin
                    mem_req_ready = 1; hs_pend = 1;
                    if (v.early) begin
                        mem_rsp_valid = 1; mem_rsp_rdata = ~v.rdata;
                    end
                end
            end
            done = !lsu_stall;
            @(posedge clk);
            #1;
            mem_req_ready = 0; mem_rsp_valid = 0;
            if (hs_pend && !seen_we) rsp_cnt = v.dly;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(v.exp_lat));
        chk({tag, ".stall_cycles"}, 64'(stalls), 64'(v.exp_lat - 1));
        chk({tag, ".req_valid_cycles"}, 64'(nvalid), 64'(v.exp_nvalid));
        if (v.exp_nvalid > 0) begin
            chk({tag, ".req_addr"}, s_addr, v.exp_addr);
            chk({tag, ".req_we"}, 64'(seen_we), 64'(v.exp_we));
            if (v.exp_we) begin
                chk({tag, ".req_wmask"}, 64'(s_wmask), 64'(v.exp_wmask));
                chk({tag, ".req_wdata"}, s_wdata, v.exp_wdata);
            end
        end
        chk({tag, ".execute_en"}, 64'(lsu_execute_en), 64'(v.exec));
        chk({tag, ".wb_en"}, 64'(lsu_wb_en), 64'(v.exp_wb));
        chk({tag, ".misalign"}, 64'(lsu_misalign), 64'(v.exp_mis));
        chk({tag, ".bus_err"}, 64'(lsu_bus_err), 64'(v.exp_berr));
        chk({tag, ".load_data"}, lsu_load_data, v.exp_ldata);
        chk({tag, ".alu_result"}, lsu_alu_result, v.addr);
        chk({tag, ".pc"}, lsu_pc, 64'h8000_0000 + 64'(idx * 4));
        chk({tag, ".index_rd"}, 64'(lsu_index_rd), 64'(idx + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---- vector table (expected values worked out by hand) ----
        tbl[0]  = mk_alu(64'h1234);
        tbl[1]  = mk_st(4'b0100, 64'h8000_0004, 64'hDEAD_BEEF, 3, 64'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b0);
        tbl[2]  = mk_ld(3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 3, 6, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        tbl[3]  = mk_ld(3'b100, 64'h8000_0003, 64'h0000_0000_8000_0000, 1, 4, 64'h8000_0000, 64'h80, 1'b0);
        tbl[4]  = mk_ld(3'b010, 64'h8000_0002, 64'h0, 1, 1, 64'h0, 64'h0, 1'b1);
        tbl[5]  = mk_ld(3'b001, 64'h8000_0006, 64'h8001_2345_6789_ABCD, 1, 4, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        tbl[6]  = mk_ld(3'b101, 64'h8000_0006, 64'h8001_2345_6789_ABCD, 1, 4, 64'h8000_0000, 64'h8001, 1'b0);
        tbl[7]  = mk_ld(3'b010, 64'h1004, 64'hF000_0001_0000_0000, 1, 4, 64'h1000, 64'hFFFF_FFFF_F000_0001, 1'b0);
        tbl[8]  = mk_ld(3'b110, 64'h1004, 64'hF000_0001_0000_0000, 1, 4, 64'h1000, 64'h0000_0000_F000_0001, 1'b0);
        tbl[9]  = mk_ld(3'b011, 64'h1000, 64'h0123_4567_89AB_CDEF, 1, 4, 64'h1000, 64'h0123_4567_89AB_CDEF, 1'b0);
        tbl[10] = mk_st(4'b0001, 64'h2005, 64'h1122_3344_5566_77AB, 3, 64'h2000, 8'h20, 64'h6677_AB00_0000_0000, 1'b0);
        tbl[11] = mk_st(4'b0010, 64'h2006, 64'h0000_0000_0000_BEEF, 3, 64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0);
        tbl[12] = mk_st(4'b1000, 64'h3000, 64'hCAFE_F00D_1234_5678, 3, 64'h3000, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0);
        tbl[13] = mk_st(4'b1000, 64'h3004, 64'h1, 1, 64'h0, 8'h00, 64'h0, 1'b1);
        tbl[14] = mk_st(4'b0010, 64'h2001, 64'h1, 1, 64'h0, 8'h00, 64'h0, 1'b1);
        // response coinciding with the handshake must be ignored
        tbl[15] = mk_ld(3'b011, 64'h5000, 64'h1122_3344_5566_7788, 2, 5, 64'h5000, 64'h1122_3344_5566_7788, 1'b0);
        tbl[15].early = 1'b1;
        // ready never arrives: 255 request cycles, then bus error
        tbl[16] = mk_ld(3'b011, 64'h4000, 64'h0, 1, 257, 64'h4000, 64'h0, 1'b0);
        tbl[16].rdy = 1'b0; tbl[16].exp_nvalid = 255; tbl[16].exp_wb = 1'b0; tbl[16].exp_berr = 1'b1;
        tbl[17] = mk_alu(64'hABCD);
        // load without execute_en is not a memory op
        tbl[18] = mk_ld(3'b010, 64'h10, 64'h0, 1, 1, 64'h0, 64'h0, 1'b0);
        tbl[18].exec = 1'b0; tbl[18].wb_in = 1'b0; tbl[18].exp_wb = 1'b0; tbl[18].exp_nvalid = 0;

        // ---- reset state ----
        rstn = 1'b0;
        drive_idle();
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.req_valid", 64'(mem_req_valid), 64'h0);
        chk("reset.stall", 64'(lsu_stall), 64'h0);
        chk("reset.execute_en", 64'(lsu_execute_en), 64'h0);
        chk("reset.req_addr", mem_req_addr, 64'h0);
        chk("reset.load_data", lsu_load_data, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ---- table ----
        for (int i = 0; i < 19; i++) begin
            run_vec($sformatf("v%0d", i), tbl[i], i);
        end
        drive_idle();

        // ---- reset while in REQ: request drops immediately ----
        exu_execute_en = 1; exu_load_en = 1; exu_load_opcode = 3'b011;
        exu_alu_result = 64'h6000; exu_wb_en = 1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req.valid_before", 64'(mem_req_valid), 64'h1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_req.valid_after", 64'(mem_req_valid), 64'h0);
        chk("rst_req.addr_after", mem_req_addr, 64'h0);
        drive_idle();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // ---- reset while in RSP, then a late response ----
        exu_execute_en = 1; exu_load_en = 1; exu_load_opcode = 3'b011;
        exu_alu_result = 64'h6008; exu_wb_en = 1; exu_pc = 64'h100;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        mem_req_ready = 1;
        chk("rst_rsp.req_valid", 64'(mem_req_valid), 64'h1);
        @(posedge clk); #1;
        mem_req_ready = 0;
        chk("rst_rsp.stall_in_rsp", 64'(lsu_stall), 64'h1);
        chk("rst_rsp.addr_in_rsp", mem_req_addr, 64'h6008);
        drive_idle();
        #2 rstn = 1'b0;
        #1;
        chk("rst_rsp.req_valid_after", 64'(mem_req_valid), 64'h0);
        chk("rst_rsp.addr_after", mem_req_addr, 64'h0);
        chk("rst_rsp.stall_after", 64'(lsu_stall), 64'h0);
        chk("rst_rsp.execute_en_after", 64'(lsu_execute_en), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        mem_rsp_valid = 1; mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        chk("late_rsp.execute_en", 64'(lsu_execute_en), 64'h0);
        chk("late_rsp.load_data", lsu_load_data, 64'h0);
        chk("late_rsp.req_valid", 64'(mem_req_valid), 64'h0);
        chk("late_rsp.stall", 64'(lsu_stall), 64'h0);

        // ---- pipeline operates normally after reset ----
        run_vec("post_rst", tbl[9], 9);
        drive_idle();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Memory-access stage of the 5-stage RV64 pipeline; consumes the EX→MEM register outputs (exu_*) and produces the MEM→WB register (lsu_*).
- Turns exu_load_en/exu_store_en into a valid/ready request plus a response-valid transaction on the data-memory port.
- Stalls upstream stages while a transaction is in flight.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- XLEN, 64, data/address width.
- TIMEOUT_CYC, 255, max cycles waiting in REQ or RSP before a bus error is declared.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- exu_execute_en  in  1  instruction in EX register is valid
- exu_load_en / exu_store_en  in  1  memory operation type
- exu_load_opcode  in  3  funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- exu_store_len  in  4  one-hot: 0001 B, 0010 H, 0100 W, 1000 D
- exu_alu_result  in  XLEN  effective address / ALU result
- exu_gpr_data2  in  XLEN  store data
- exu_index_rd  in  5; exu_wb_en  in  1; exu_wb_choose  in  4; exu_ebreak  in  1
- exu_pc, exu_snxt_pc  in  XLEN; exu_instr  in  32
- mem_req_valid  out  1; mem_req_ready  in  1
- mem_req_we  out  1; mem_req_addr  out  XLEN (8-byte aligned)
- mem_req_wdata  out  XLEN; mem_req_wmask  out  8
- mem_rsp_valid  in  1; mem_rsp_rdata  in  XLEN
- lsu_stall  out  1  hold IF/ID/EX registers
- lsu_execute_en, lsu_wb_en, lsu_ebreak  out  1
- lsu_index_rd  out  5; lsu_wb_choose  out  4
- lsu_alu_result, lsu_load_data, lsu_pc, lsu_snxt_pc  out  XLEN; lsu_instr  out  32
- lsu_misalign, lsu_bus_err  out  1  exception flags travelling with the instruction

Behaviour:
- Reset (async, rstn=0): state IDLE, timeout counter 0. All lsu_* outputs 0, mem_req_valid 0, request registers 0.
- mem_op = exu_execute_en & (exu_load_en | exu_store_en).
- Misaligned access: offset=addr[2:0]; H with offset odd, W with offset[1:0]≠0, D with offset≠0.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - If mem_op and aligned: latch addr&~7, we, wmask, shifted wdata, load opcode and offset; go to REQ. lsu_stall=1 (combinational from inputs).
  - If mem_op and misaligned: no request; lsu_stall=0; output register captures the instruction with lsu_misalign=1, lsu_wb_en=0, lsu_load_data=0.
  - Otherwise: lsu_stall=0; output register captures the exu_* fields.
- REQ: mem_req_valid=1 and request fields held stable until mem_req_ready. On the handshake, a store goes to DONE and a load goes to RSP. lsu_stall=1.
- RSP: on mem_rsp_valid, latch rdata and go to DONE. lsu_stall=1.
- DONE: lsu_stall=0. Output register captures the held exu_* fields plus the formatted load data. Go to IDLE.
- While stalled (REQ, RSP, or IDLE with mem_op): output register loads a bubble: lsu_execute_en=0, lsu_wb_en=0, lsu_ebreak=0; other fields don't-care.
- Timeout: counter counts cycles in REQ/RSP and clears on entry to REQ. At TIMEOUT_CYC: drop mem_req_valid, go to DONE, set lsu_bus_err=1 and lsu_wb_en=0 for that instruction. A late rsp in IDLE is ignored.
- Store formatting:
  - wmask: B 8'h01<<off, H 8'h03<<off, W 8'h0F<<off, D 8'hFF.
  - wdata = gpr_data2 << (off*8).
- Load formatting:
  - shifted = rdata >> (off*8); take low 8/16/32/64 bits.
  - Sign-extend for 000/001/010; zero-extend for 100/101/110.
  - lsu_load_data=0 for stores and non-memory instructions.
- Latency:
  - Non-memory: 1 cycle.
  - Store with ready=1: 3 cycles (IDLE, REQ, DONE).
  - Load with ready=1 and rsp the next cycle: 4 cycles.
- Reset mid-transaction: aborts immediately with no further request. Memory is reset on the same rstn.
- Simultaneous mem_req_ready and mem_rsp_valid in REQ: rsp is ignored. A response is only legal after the handshake.

Decomposition:
- Package lsu_pkg: load funct3 localparams, store_len one-hot codes, FSM state encoding (2 bits), TIMEOUT_CYC default.
- Sub-module lsu_load_align (combinational): rdata, offset, load_opcode → extended load data.

Test Plan:
- ADD instr, wb_en=1, alu_result=0x1234 → next cycle lsu_alu_result=0x1234, lsu_wb_en=1, lsu_stall never asserted.
- SW addr=0x8000_0004, data=0xDEADBEEF, ready=1 → mem_req_addr=0x8000_0000, wmask=0xF0, wdata=0xDEADBEEF_00000000, we=1; lsu_stall high for exactly 2 cycles.
- LB addr=0x8000_0003, rdata=0x0000_0000_8000_0000, rsp 3 cycles after handshake → lsu_load_data=0xFFFF_FFFF_FFFF_FF80. LBU of the same → 0x80.
- LW addr=0x8000_0002 → no mem_req_valid, lsu_misalign=1, lsu_wb_en=0, lsu_stall=0.
- LD with ready held 0 for TIMEOUT_CYC cycles → mem_req_valid drops, lsu_bus_err=1, pipeline resumes.
- rstn pulsed low while in RSP → asynchronously state=IDLE, mem_req_valid=0, all lsu_* outputs 0. A subsequent rsp_valid has no effect.
